// File: rtl/jace_pkg.sv
// ---------------------------------------------------------------------------
// jace_pkg
// Shared types and constants for the Jupiter ACE video RAM arbiter.
//   VRAM_AW / VRAM_DW : default RAM geometry (1K x 8)
//   STALL_W           : width of the CPU stall counter
//   cpu_state_t       : CPU access FSM states
//   sat_inc           : saturating increment for the stall counter
// ---------------------------------------------------------------------------
package jace_pkg;

  localparam int VRAM_AW = 10;
  localparam int VRAM_DW = 8;
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_PEND = 2'd1,
    C_RD   = 2'd2,
    C_DONE = 2'd3
  } cpu_state_t;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

endpackage

// File: rtl/jace_vid_pipe.sv
// ---------------------------------------------------------------------------
// jace_vid_pipe
// Fixed-latency valid pipeline for video fetches.
//   clk, reset_n     : clock, asynchronous active-low reset
//   vid_req          : single-cycle fetch strobe
//   ram_rdata        : RAM read data (valid one cycle after the RAM issue)
//   issue_slot_busy  : the RAM port slot of the next cycle belongs to video
//   vid_issue        : video owns the RAM port in the current cycle
//   vid_data         : fetched byte, valid with vid_valid
//   vid_valid        : one-cycle pulse, three cycles after vid_req
// ---------------------------------------------------------------------------
module jace_vid_pipe
  import jace_pkg::*;
#(
  parameter int DW = VRAM_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [DW-1:0] ram_rdata,
  output logic          issue_slot_busy,
  output logic          vid_issue,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid
);

  logic          vld_p0;
  logic          vld_p1;
  logic          vld_p2;
  logic [DW-1:0] data_p2;

  // Video always wins the port, so a request claims the next slot outright.
  assign issue_slot_busy = vid_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      // p0: RAM issue cycle
      vld_p0 <= vid_req;
      // p1: RAM read data valid on ram_rdata
      vld_p1 <= vld_p0;
      // p2: registered result presented to the fetcher
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= ram_rdata;
    end
  end

  assign vid_issue = vld_p0;
  assign vid_data  = data_p2;
  assign vid_valid = vld_p2;

endmodule

// File: rtl/jace_vram_arbiter.sv
// ---------------------------------------------------------------------------
// jace_vram_arbiter
// Shares one single-port video RAM between the Z80 and the video fetcher.
// Video fetches have fixed latency 3; the CPU uses free port cycles and is
// held off through cpu_wait_n.
//   clk, reset_n                     : clk_65 domain, async active-low reset
//   vid_active, vid_req, vid_addr    : video timing / fetch request
//   vid_data, vid_valid              : fetch result
//   cpu_sel, cpu_we, cpu_addr,
//   cpu_wdata                        : CPU access request (level)
//   cpu_rdata, cpu_wait_n            : CPU read data / wait
//   ram_ce, ram_we, ram_addr,
//   ram_wdata, ram_rdata             : RAM primitive port
//   stall_cnt                        : wait cycles of the last completed access
// ---------------------------------------------------------------------------
module jace_vram_arbiter
  import jace_pkg::*;
#(
  parameter int AW              = VRAM_AW,
  parameter int DW              = VRAM_DW,
  parameter bit BLOCK_IN_ACTIVE = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vid_active,
  input  logic               vid_req,
  input  logic [AW-1:0]      vid_addr,
  output logic [DW-1:0]      vid_data,
  output logic               vid_valid,
  input  logic               cpu_sel,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_wait_n,
  output logic               ram_ce,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_rdata,
  output logic [STALL_W-1:0] stall_cnt
);

  logic               issue_slot_busy;
  logic               vid_issue;
  logic               cpu_issue;
  logic               cpu_iss_p0;
  logic               cpu_rd_p1;
  logic [STALL_W-1:0] stall_acc;
  cpu_state_t         state;

  jace_vid_pipe #(.DW(DW)) u_vid_pipe (
    .clk             (clk),
    .reset_n         (reset_n),
    .vid_req         (vid_req),
    .ram_rdata       (ram_rdata),
    .issue_slot_busy (issue_slot_busy),
    .vid_issue       (vid_issue),
    .vid_data        (vid_data),
    .vid_valid       (vid_valid)
  );

  // CPU may take the next port slot only when video has not claimed it and,
  // in authentic mode, the display is outside the active area.
  assign cpu_issue = (state == C_PEND) && cpu_sel && !issue_slot_busy &&
                     !(BLOCK_IN_ACTIVE && vid_active);

  // Combinational so the Z80 sees wait in the same clk_65 cycle it selects;
  // forced high during reset.
  assign cpu_wait_n = ~(reset_n & cpu_sel & (state != C_DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= C_IDLE;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_rdata  <= '0;
      cpu_iss_p0 <= 1'b0;
      cpu_rd_p1  <= 1'b0;
      stall_acc  <= '0;
      stall_cnt  <= '0;
    end else begin
      // p0: RAM port registers, video has priority
      ram_ce <= issue_slot_busy | cpu_issue;
      ram_we <= cpu_issue & cpu_we;
      if (issue_slot_busy) begin
        ram_addr <= vid_addr;
      end else if (cpu_issue) begin
        ram_addr <= cpu_addr;
      end
      if (cpu_issue && cpu_we) ram_wdata <= cpu_wdata;
      cpu_iss_p0 <= cpu_issue;
      // p1: CPU read data valid on ram_rdata
      cpu_rd_p1  <= cpu_iss_p0 & ~ram_we;

      if (!cpu_wait_n) stall_acc <= sat_inc(stall_acc);

      case (state)
        C_IDLE: begin
          if (cpu_sel) begin
            state     <= C_PEND;
            // Restart the count including the selecting cycle itself.
            stall_acc <= STALL_W'(1);
          end
        end
        C_PEND: begin
          if (!cpu_sel) begin
            state <= C_IDLE;
          end else if (cpu_issue) begin
            if (cpu_we) begin
              state     <= C_DONE;
              stall_cnt <= sat_inc(stall_acc);
            end else begin
              state <= C_RD;
            end
          end
        end
        C_RD: begin
          // A deselected read still completes so the RAM sequence stays clean.
          if (cpu_rd_p1) begin
            cpu_rdata <= ram_rdata;
            if (cpu_sel) begin
              state     <= C_DONE;
              stall_cnt <= sat_inc(stall_acc);
            end else begin
              state <= C_IDLE;
            end
          end
        end
        C_DONE: begin
          if (!cpu_sel) state <= C_IDLE;
        end
        default: state <= C_IDLE;
      endcase
    end
  end

  a_one_port_owner: assert property (@(posedge clk) disable iff (!reset_n)
    !(vid_issue && cpu_iss_p0));

endmodule

// File: tb/tb_jace_vram_arbiter.sv
module tb_jace_vram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset_n = 1'b1;
  logic       vid_active = 1'b0;
  logic       vid_req = 1'b0;
  logic [9:0] vid_addr = '0;
  logic       cpu_sel = 1'b0;
  logic       cpu_we = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;

  logic [7:0]  vid_data_a, vid_data_b, cpu_rdata_a, cpu_rdata_b;
  logic        vid_valid_a, vid_valid_b, cpu_wait_n_a, cpu_wait_n_b;
  logic        ram_ce_a, ram_ce_b, ram_we_a, ram_we_b;
  logic [9:0]  ram_addr_a, ram_addr_b;
  logic [7:0]  ram_wdata_a, ram_wdata_b;
  logic [7:0]  ram_rdata_a = '0, ram_rdata_b = '0;
  logic [15:0] stall_cnt_a, stall_cnt_b;

  jace_vram_arbiter #(.AW(10), .DW(8), .BLOCK_IN_ACTIVE(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .vid_active(vid_active), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_data(vid_data_a), .vid_valid(vid_valid_a),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_a), .cpu_wait_n(cpu_wait_n_a), .ram_ce(ram_ce_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata_a), .stall_cnt(stall_cnt_a)
  );

  jace_vram_arbiter #(.AW(10), .DW(8), .BLOCK_IN_ACTIVE(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .vid_active(vid_active), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_data(vid_data_b), .vid_valid(vid_valid_b),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_b), .cpu_wait_n(cpu_wait_n_b), .ram_ce(ram_ce_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b), .stall_cnt(stall_cnt_b)
  );

  function automatic logic [7:0] ref_init(input logic [9:0] a);
    if (a == 10'h123) return 8'h5A;
    return a[7:0] ^ 8'hA3 ^ {6'd0, a[9:8]};
  endfunction

  // Synchronous single-port RAM models, one per DUT.
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];
  logic [7:0] ref_mem [1024];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) begin
        mem_a[i] <= ref_init(10'(i));
        mem_b[i] <= ref_init(10'(i));
      end
      loaded <= 1'b1;
    end else begin
      if (ram_ce_a) begin
        if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
        ram_rdata_a <= mem_a[ram_addr_a];
      end
      if (ram_ce_b) begin
        if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        ram_rdata_b <= mem_b[ram_addr_b];
      end
    end
  end

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t vq_a[$];
  exp_t vq_b[$];

  int total = 0;
  int bad = 0;

  // Video scoreboard: every vid_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (vid_valid_a) begin
      total++;
      if (vq_a.size() == 0) begin
        bad++;
        $display("FAIL vid_a_unexpected cyc=%0d got=%h want=no pulse", cyc, vid_data_a);
      end else begin
        e = vq_a.pop_front();
        if (vid_data_a !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL vid_a_data got=%h@%0d want=%h@%0d", vid_data_a, cyc, e.data, e.cyc);
        end
      end
    end
    if (vid_valid_b) begin
      total++;
      if (vq_b.size() == 0) begin
        bad++;
        $display("FAIL vid_b_unexpected cyc=%0d got=%h want=no pulse", cyc, vid_data_b);
      end else begin
        e = vq_b.pop_front();
        if (vid_data_b !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL vid_b_data got=%h@%0d want=%h@%0d", vid_data_b, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vid_fetch(input logic [9:0] a);
    exp_t e;
    vid_req  = 1'b1;
    vid_addr = a;
    e.cyc    = cyc + 3;
    e.data   = ref_mem[a];
    vq_a.push_back(e);
    vq_b.push_back(e);
  endtask

  // Drives one CPU access and counts the cycles cpu_wait_n (dut_a) stays low.
  task automatic run_access(input logic we, input logic [9:0] a, input logic [7:0] d,
                            input bit rnd, output int meas, output bit to);
    step();
    cpu_sel = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) ref_mem[a] = d;
    meas = 0;
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (rnd && $urandom_range(0, 1) == 1) vid_fetch({2'b10, 8'($urandom)});
      else vid_req = 1'b0;
      #2;
      if (cpu_wait_n_a) begin
        to = 1'b0;
        break;
      end
      meas++;
      step();
    end
    step();
    cpu_sel = 1'b0;
    vid_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    cpu_sel = 1'b1;
    step(); step();
    #2;
    total++; if (cpu_wait_n_a !== 1'b1) begin bad++; $display("FAIL rst_wait_n_a got=%b want=1", cpu_wait_n_a); end
    total++; if (cpu_wait_n_b !== 1'b1) begin bad++; $display("FAIL rst_wait_n_b got=%b want=1", cpu_wait_n_b); end
    total++; if (ram_ce_a !== 1'b0 || ram_we_a !== 1'b0) begin bad++; $display("FAIL rst_ram_ctl got=%b%b want=00", ram_ce_a, ram_we_a); end
    total++; if (vid_valid_a !== 1'b0) begin bad++; $display("FAIL rst_vid_valid got=%b want=0", vid_valid_a); end
    total++; if (stall_cnt_a !== 16'h0) begin bad++; $display("FAIL rst_stall got=%h want=0", stall_cnt_a); end
    total++; if (cpu_rdata_a !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", cpu_rdata_a); end
    step();
    cpu_sel = 1'b0;
    reset_n = 1'b1;
    step(); step();
  endtask

  task automatic test_vid_fetch();
    step();
    vid_fetch(10'h123);
    step();
    vid_req = 1'b0;
    #2;
    total++; if (ram_ce_a !== 1'b1 || ram_we_a !== 1'b0) begin bad++; $display("FAIL vid_issue_ctl got=%b%b want=10", ram_ce_a, ram_we_a); end
    total++; if (ram_addr_a !== 10'h123) begin bad++; $display("FAIL vid_issue_addr got=%h want=123", ram_addr_a); end
    step();
    #2;
    total++; if (ram_ce_a !== 1'b0) begin bad++; $display("FAIL vid_issue_single got=%b want=0", ram_ce_a); end
    repeat (4) step();
    total++; if (vq_a.size() != 0) begin bad++; $display("FAIL vid_pending got=%0d want=0", vq_a.size()); end
  endtask

  task automatic test_write_read();
    int meas;
    bit to;
    step();
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3C0; cpu_wdata = 8'hA5;
    ref_mem[10'h3C0] = 8'hA5;
    #2;
    total++; if (cpu_wait_n_b !== 1'b0) begin bad++; $display("FAIL wr_wait_same_cycle got=%b want=0", cpu_wait_n_b); end
    step();
    #2;
    total++; if (ram_ce_b !== 1'b0) begin bad++; $display("FAIL wr_early_issue got=%b want=0", ram_ce_b); end
    step();
    #2;
    total++; if (ram_we_b !== 1'b1 || ram_ce_b !== 1'b1) begin bad++; $display("FAIL wr_issue got=%b%b want=11", ram_ce_b, ram_we_b); end
    total++; if (ram_addr_b !== 10'h3C0 || ram_wdata_b !== 8'hA5) begin bad++; $display("FAIL wr_addr_data got=%h/%h want=3c0/a5", ram_addr_b, ram_wdata_b); end
    total++; if (cpu_wait_n_b !== 1'b1) begin bad++; $display("FAIL wr_wait_release got=%b want=1", cpu_wait_n_b); end
    step();
    #2;
    total++; if (ram_we_b !== 1'b0) begin bad++; $display("FAIL wr_we_one_cycle got=%b want=0", ram_we_b); end
    total++; if (stall_cnt_b !== 16'd2) begin bad++; $display("FAIL wr_stall got=%0d want=2", stall_cnt_b); end
    cpu_sel = 1'b0;
    run_access(1'b0, 10'h3C0, 8'h00, 1'b0, meas, to);
    total++; if (to) begin bad++; $display("FAIL rd_timeout got=timeout want=wait_n high"); end
    total++; if (cpu_rdata_b !== 8'hA5 || cpu_rdata_a !== 8'hA5) begin bad++; $display("FAIL rd_back got=%h/%h want=a5", cpu_rdata_a, cpu_rdata_b); end
    total++; if (stall_cnt_a !== 16'(meas)) begin bad++; $display("FAIL rd_stall got=%0d want=%0d", stall_cnt_a, meas); end
  endtask

  task automatic test_starve();
    int meas, hi, c;
    step();
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h045;
    meas = 0; hi = 0;
    #2; if (!cpu_wait_n_a) meas++;
    for (int i = 0; i < 20; i++) begin
      step();
      vid_fetch(10'(10'h200 + i));
      #2;
      if (cpu_wait_n_a) hi++; else meas++;
    end
    total++; if (hi != 0) begin bad++; $display("FAIL starve_wait_high got=%0d want=0", hi); end
    step();
    vid_req = 1'b0;
    #2; if (!cpu_wait_n_a) meas++;
    total++; if (ram_ce_a !== 1'b1 || ram_addr_a !== 10'h213) begin bad++; $display("FAIL starve_last_vid got=%b/%h want=1/213", ram_ce_a, ram_addr_a); end
    step();
    #2; if (!cpu_wait_n_a) meas++;
    total++; if (ram_ce_a !== 1'b1 || ram_we_a !== 1'b0 || ram_addr_a !== 10'h045) begin bad++; $display("FAIL starve_cpu_issue got=%b%b/%h want=10/045", ram_ce_a, ram_we_a, ram_addr_a); end
    for (c = 0; c < 50; c++) begin
      step();
      #2;
      if (cpu_wait_n_a) break;
      meas++;
    end
    total++; if (c >= 50) begin bad++; $display("FAIL starve_timeout got=timeout want=wait_n high"); end
    total++; if (stall_cnt_a !== 16'(meas) || meas < 21) begin bad++; $display("FAIL starve_stall got=%0d want=%0d (>=21)", stall_cnt_a, meas); end
    total++; if (cpu_rdata_a !== ref_mem[10'h045]) begin bad++; $display("FAIL starve_rdata got=%h want=%h", cpu_rdata_a, ref_mem[10'h045]); end
    step();
    cpu_sel = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_block_active();
    int meas, hits, c;
    step();
    vid_active = 1'b1;
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h111;
    meas = 0; hits = 0;
    #2; if (!cpu_wait_n_a) meas++;
    for (int i = 0; i < 50; i++) begin
      step();
      #2;
      if (ram_ce_a) hits++;
      if (!cpu_wait_n_a) meas++;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL blk_issue_in_active got=%0d want=0", hits); end
    total++; if (cpu_wait_n_b !== 1'b1 || cpu_rdata_b !== ref_mem[10'h111]) begin bad++; $display("FAIL blk_free_mode got=%b/%h want=1/%h", cpu_wait_n_b, cpu_rdata_b, ref_mem[10'h111]); end
    step();
    vid_active = 1'b0;
    #2; if (!cpu_wait_n_a) meas++;
    total++; if (ram_ce_a !== 1'b0) begin bad++; $display("FAIL blk_issue_early got=%b want=0", ram_ce_a); end
    step();
    #2; if (!cpu_wait_n_a) meas++;
    total++; if (ram_ce_a !== 1'b1 || ram_addr_a !== 10'h111) begin bad++; $display("FAIL blk_issue got=%b/%h want=1/111", ram_ce_a, ram_addr_a); end
    for (c = 0; c < 50; c++) begin
      step();
      #2;
      if (cpu_wait_n_a) break;
      meas++;
    end
    total++; if (c >= 50) begin bad++; $display("FAIL blk_timeout got=timeout want=wait_n high"); end
    total++; if (stall_cnt_a !== 16'(meas) || cpu_rdata_a !== ref_mem[10'h111]) begin bad++; $display("FAIL blk_result got=%0d/%h want=%0d/%h", stall_cnt_a, cpu_rdata_a, meas, ref_mem[10'h111]); end
    step();
    cpu_sel = 1'b0;
  endtask

  task automatic test_same_cycle();
    int c;
    step();
    vid_fetch(10'h2AA);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0F0;
    step();
    vid_req = 1'b0;
    #2;
    total++; if (ram_ce_a !== 1'b1 || ram_we_a !== 1'b0 || ram_addr_a !== 10'h2AA) begin bad++; $display("FAIL same_vid_first got=%b%b/%h want=10/2aa", ram_ce_a, ram_we_a, ram_addr_a); end
    step();
    #2;
    total++; if (ram_ce_a !== 1'b1 || ram_addr_a !== 10'h0F0) begin bad++; $display("FAIL same_cpu_next got=%b/%h want=1/0f0", ram_ce_a, ram_addr_a); end
    for (c = 0; c < 50; c++) begin
      if (cpu_wait_n_a) break;
      step();
      #2;
    end
    total++; if (c >= 50 || cpu_rdata_a !== ref_mem[10'h0F0]) begin bad++; $display("FAIL same_rdata got=%h want=%h", cpu_rdata_a, ref_mem[10'h0F0]); end
    step();
    cpu_sel = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    int meas;
    bit to;
    logic [9:0] a;
    logic [7:0] d;
    for (int k = 0; k < 8; k++) begin
      a = 10'(10'h300 + 7 * (k % 4));
      d = 8'($urandom);
      run_access(k < 4, a, d, 1'b1, meas, to);
      total++; if (to) begin bad++; $display("FAIL b2b_timeout k=%0d got=timeout want=wait_n high", k); end
      total++; if (stall_cnt_a !== 16'(meas)) begin bad++; $display("FAIL b2b_stall k=%0d got=%0d want=%0d", k, stall_cnt_a, meas); end
      if (k >= 4) begin
        total++;
        if (cpu_rdata_a !== ref_mem[a] || cpu_rdata_b !== ref_mem[a]) begin
          bad++; $display("FAIL b2b_rdata k=%0d got=%h/%h want=%h", k, cpu_rdata_a, cpu_rdata_b, ref_mem[a]);
        end
      end
    end
    repeat (4) step();
    total++; if (vq_a.size() != 0 || vq_b.size() != 0) begin bad++; $display("FAIL b2b_vid_pending got=%0d/%0d want=0", vq_a.size(), vq_b.size()); end
  endtask

  task automatic test_abort();
    int hits, meas;
    bit to;
    step();
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3F0; cpu_wdata = 8'hEE;
    step();
    cpu_sel = 1'b0;
    hits = 0;
    repeat (6) begin
      #2;
      if (ram_ce_a || ram_ce_b || !cpu_wait_n_a) hits++;
      step();
    end
    total++; if (hits != 0) begin bad++; $display("FAIL abort_activity got=%0d want=0", hits); end
    run_access(1'b0, 10'h3F0, 8'h00, 1'b0, meas, to);
    total++; if (to || cpu_rdata_a !== ref_mem[10'h3F0]) begin bad++; $display("FAIL abort_mem got=%h want=%h", cpu_rdata_a, ref_mem[10'h3F0]); end
  endtask

  task automatic test_reset_mid();
    int hits, meas;
    bit to;
    step();
    vid_fetch(10'h250);
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3D0; cpu_wdata = 8'h77;
    step();
    vid_req = 1'b0;
    reset_n = 1'b0;
    #2;
    total++; if (cpu_wait_n_a !== 1'b1 || ram_ce_a !== 1'b0) begin bad++; $display("FAIL rmid_in_reset got=%b/%b want=1/0", cpu_wait_n_a, ram_ce_a); end
    vq_a.delete();
    vq_b.delete();
    cpu_sel = 1'b0;
    hits = 0;
    repeat (3) begin
      step();
      #2;
      if (ram_we_a || ram_ce_a) hits++;
    end
    step();
    reset_n = 1'b1;
    repeat (5) begin
      step();
      #2;
      if (ram_we_a || ram_ce_a || vid_valid_a) hits++;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL rmid_activity got=%0d want=0", hits); end
    total++; if (cpu_wait_n_a !== 1'b1 || stall_cnt_a !== 16'h0 || cpu_rdata_a !== 8'h00) begin bad++; $display("FAIL rmid_state got=%b/%h/%h want=1/0/00", cpu_wait_n_a, stall_cnt_a, cpu_rdata_a); end
    run_access(1'b0, 10'h3D0, 8'h00, 1'b0, meas, to);
    total++; if (to || cpu_rdata_a !== ref_mem[10'h3D0]) begin bad++; $display("FAIL rmid_mem got=%h want=%h", cpu_rdata_a, ref_mem[10'h3D0]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = ref_init(10'(i));
    test_reset();
    test_vid_fetch();
    test_write_read();
    test_starve();
    test_block_active();
    test_same_cycle();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    repeat (4) step();
    total++; if (vq_a.size() != 0 || vq_b.size() != 0) begin bad++; $display("FAIL final_vid_pending got=%0d/%0d want=0", vq_a.size(), vq_b.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
